reg_cmd_initiator: RTL

- Register-interface initiator (requester side) that converts a simple valid/ready command stream into single register-bus transactions.
- Returns each transaction's outcome as a valid/ready result stream: read data, bus error flag and timeout flag.
- Sits between a controller (DMA descriptor engine, debug/config sequencer) and a reg_req/reg_rsp bus, demux or peripheral.
- A built-in watchdog terminates transactions the responder never completes, so an unpopulated address cannot hang the controller.

---
 rtl/reg_cmd_initiator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/reg_cmd_initiator.sv
// Register-bus initiator: turns a valid/ready command stream into single
// reg_req/reg_rsp transactions and returns each outcome as a valid/ready
// result. A watchdog aborts requests that the responder never completes.

package reg_cmd_initiator_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module reg_cmd_initiator #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter type         req_t          = reg_cmd_initiator_pkg::reg_req_t,
  parameter type         rsp_t          = reg_cmd_initiator_pkg::reg_rsp_t
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic            cmd_write_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_wstrb_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [DW-1:0]   res_rdata_o,
  output logic            res_error_o,
  output logic            res_timeout_o,
  output req_t            reg_req_o,
  input  rsp_t            reg_rsp_i,
  output logic            busy_o
);

  // Counter is wide enough to hold TIMEOUT_CYCLES; at least one bit.
  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;

  // Single FSM: the request register doubles as the latched command, and all
  // handshake/status outputs are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_o   <= 1'b1;
      res_valid_o   <= 1'b0;
      res_rdata_o   <= '0;
      res_error_o   <= 1'b0;
      res_timeout_o <= 1'b0;
      reg_req_o     <= '0;
      busy_o        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            reg_req_o.addr  <= cmd_addr_i;
            reg_req_o.write <= cmd_write_i;
            reg_req_o.wdata <= cmd_write_i ? cmd_wdata_i : '0;
            reg_req_o.wstrb <= cmd_write_i ? cmd_wstrb_i : '0;
            reg_req_o.valid <= 1'b1;
            cnt_q           <= '0;
            cmd_ready_o     <= 1'b0;
            busy_o          <= 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          if (reg_rsp_i.ready) begin
            // Completion takes priority over a watchdog expiry in the same cycle.
            res_rdata_o     <= reg_req_o.write ? '0 : reg_rsp_i.rdata;
            res_error_o     <= reg_rsp_i.error;
            res_timeout_o   <= 1'b0;
            res_valid_o     <= 1'b1;
            reg_req_o.valid <= 1'b0;
            state_q         <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
            res_rdata_o     <= '0;
            res_error_o     <= 1'b1;
            res_timeout_o   <= 1'b1;
            res_valid_o     <= 1'b1;
            reg_req_o.valid <= 1'b0;
            state_q         <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q         <= IDLE;
          cmd_ready_o     <= 1'b1;
          res_valid_o     <= 1'b0;
          reg_req_o.valid <= 1'b0;
          busy_o          <= 1'b0;
        end
      endcase
    end
  end

endmodule
